rv64_trap_ctrl: RTL and testbench
=================================

RV64_TRAP_CTRL -- requirements
Module: rv64_trap_ctrl

Interface
REQ-001 The module SHALL have one parameter: XLEN, default 64, datapath width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port exc_valid_i, input, 1 bit: synchronous exception request.
REQ-005 The module SHALL have ports exc_cause_i, exc_pc_i and exc_tval_i, input, XLEN each: cause code, faulting pc and trap value.
REQ-006 The module SHALL have port mret_valid_i, input, 1 bit: committed mret request.
REQ-007 The module SHALL have port irq_timer_i, input, 1 bit: machine timer interrupt pending (level).
REQ-008 The module SHALL have ports commit_pc_valid_i (input, 1 bit) and commit_pc_i (input, XLEN): next pc to execute at an interruptible boundary.
REQ-009 The module SHALL have port req_ready_o, output, 1 bit: request accept, shared by exception, interrupt and mret.
REQ-010 The module SHALL have ports csr_mstatus_i, csr_mepc_i and csr_mtvec_i, input, XLEN each: current CSR values from the CSR register file.
REQ-011 The module SHALL have CSR write ports csr_mstatus_o, csr_mepc_o, csr_mcause_o and csr_mtval_o, output, XLEN each.
REQ-012 The module SHALL have one-cycle write strobes csr_mstatus_valid_o, csr_mepc_valid_o, csr_mcause_valid_o and csr_mtval_valid_o, output, 1 bit each.
REQ-013 The module SHALL have ports redirect_valid_o (output, 1 bit), redirect_pc_o (output, XLEN) and redirect_ready_i (input, 1 bit): fetch redirect handshake.
REQ-014 The module SHALL have port flush_o, output, 1 bit: pipeline flush.

Function
REQ-015 The FSM SHALL have the states IDLE, TRAP_WR, MRET_WR and REDIRECT.
REQ-016 req_ready_o SHALL be 1 exactly when the state is IDLE.
REQ-017 In IDLE the accept priority SHALL be: exc_valid_i, then interrupt, then mret_valid_i; a lower-priority request in the same cycle is not accepted and must be re-presented.
REQ-018 An interrupt SHALL be taken when irq_timer_i=1, csr_mstatus_i[3] (MIE)=1 and commit_pc_valid_i=1.
REQ-019 On accept the module SHALL capture pc, cause, tval and mtvec into internal registers, then change state.
  - exception: mepc=exc_pc_i, mcause=exc_cause_i, mtval=exc_tval_i.
  - interrupt: mepc=commit_pc_i, mcause={1'b1, (XLEN-1)'d7}, mtval=0.
  - In both cases the next state is TRAP_WR.
  - mret: capture csr_mepc_i as the target; the next state is MRET_WR.
REQ-020 In TRAP_WR, for exactly one cycle, all four CSR strobes SHALL be 1, carrying the captured mepc/mcause/mtval and an updated mstatus.
  - MPIE(bit 7) = old MIE(bit 3); MIE = 0; MPP(bits 12:11) = 2'b11; all other bits unchanged from csr_mstatus_i.
  - The next state is REDIRECT.
REQ-021 In MRET_WR, csr_mstatus_valid_o SHALL be 1 for one cycle with MIE = MPIE, MPIE = 1, MPP = 2'b11, other bits unchanged; the next state is REDIRECT.
REQ-022 The trap target SHALL be {mtvec[XLEN-1:2], 2'b00}.
  - Exception: the target is always the base.
  - Interrupt with mtvec[1:0]=2'b01: the target is base + 4*7; the addition wraps at XLEN.
REQ-023 The mret target SHALL be {mepc[XLEN-1:2], 2'b00}, i.e. the captured mepc with bits 1:0 cleared.
REQ-024 In REDIRECT, redirect_valid_o SHALL be 1 and redirect_pc_o stable until redirect_ready_i=1.
  - The state returns to IDLE on the cycle after the handshake.
  - A handshake in the first REDIRECT cycle is legal.
REQ-025 flush_o SHALL be 1 in TRAP_WR, MRET_WR and REDIRECT, and 0 in IDLE.
REQ-026 All CSR strobes SHALL be 0 in every state except TRAP_WR and MRET_WR.
REQ-027 Minimum latency SHALL be 3 cycles: accept at N, CSR write at N+1, redirect at N+2, IDLE at N+3.
REQ-028 Requests arriving while not in IDLE SHALL be ignored; there is no queuing.
REQ-029 irq_timer_i going low after an interrupt is accepted SHALL NOT abort the sequence.

Reset
REQ-030 While rst=0: state = IDLE; all captured registers = 0; all strobes, redirect_valid_o and flush_o = 0; data outputs = 0.
REQ-031 Assertion of rst mid-sequence SHALL abandon the sequence immediately: no further strobes, and no redirect after release.
REQ-032 req_ready_o SHALL be 1 in the first cycle after rst release.

Verification
REQ-033 Exception test.
  - Stimulus: exc_valid_i, cause=2, pc=0x80000100, tval=0xDEAD, mtvec=0x80001000, mstatus=0x8; redirect_ready_i=1.
  - Response: N+1 strobes with mepc=0x80000100, mcause=2, mtval=0xDEAD, mstatus=0x1880; N+2 redirect to 0x80001000.
REQ-034 Vectored timer interrupt test.
  - Stimulus: irq=1, MIE=1, commit_pc=0x80000200, mtvec=0x80001001.
  - Response: mcause=0x8000000000000007, mtval=0, mepc=0x80000200; redirect to 0x8000101C.
REQ-035 Masked interrupt and mret test.
  - irq=1 with MIE=0 -> no accept, flush_o=0.
  - mret with mstatus=0x1880, mepc=0x80000102 -> mstatus write 0x1888; redirect to 0x80000100.
REQ-036 Simultaneous requests and backpressure test.
  - Stimulus: exc_valid_i, irq (MIE=1) and mret in the same cycle; redirect_ready_i=0 for 4 cycles.
  - Response: the exception is taken; redirect_valid_o is held for 5 cycles with a stable pc; mret arriving during REDIRECT is ignored.
REQ-037 Reset test.
  - Stimulus: rst=0 asserted in TRAP_WR.
  - Response: strobes drop the same cycle; after release req_ready_o=1, redirect_valid_o=0.

Source files
------------

// File: rtl/rv64_trap_ctrl.sv
// Machine-mode trap sequencer: accepts exceptions, timer interrupts and mret,
// writes the trap CSRs for one cycle, then redirects fetch and flushes the pipe.
module rv64_trap_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_valid_i,
  input  logic            irq_timer_i,
  input  logic            commit_pc_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  output logic [XLEN-1:0] csr_mstatus_o,
  output logic [XLEN-1:0] csr_mepc_o,
  output logic [XLEN-1:0] csr_mcause_o,
  output logic [XLEN-1:0] csr_mtval_o,
  output logic            csr_mstatus_valid_o,
  output logic            csr_mepc_valid_o,
  output logic            csr_mcause_valid_o,
  output logic            csr_mtval_valid_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic            flush_o
);

  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(7)};
  localparam logic [XLEN-1:0] VEC_OFS   = XLEN'(28);

  typedef enum logic [1:0] {IDLE, TRAP_WR, MRET_WR, REDIRECT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_mepc, r_mcause, r_mtval, r_tgt;
  logic [XLEN-1:0] w_mepc_nxt, w_mcause_nxt, w_mtval_nxt, w_tgt_nxt;
  logic [XLEN-1:0] w_base;
  logic            w_irq_take, w_trap_wr, w_mret_wr;

  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // The redirect target is resolved at accept time so it stays frozen
  // through REDIRECT regardless of later CSR input changes.
  always_comb begin
    w_state_nxt  = r_state;
    w_mepc_nxt   = r_mepc;
    w_mcause_nxt = r_mcause;
    w_mtval_nxt  = r_mtval;
    w_tgt_nxt    = r_tgt;
    w_base       = {csr_mtvec_i[XLEN-1:2], 2'b00};
    w_irq_take   = irq_timer_i & csr_mstatus_i[3] & commit_pc_valid_i;
    case (r_state)
      IDLE: begin
        if (exc_valid_i) begin
          w_state_nxt  = TRAP_WR;
          w_mepc_nxt   = exc_pc_i;
          w_mcause_nxt = exc_cause_i;
          w_mtval_nxt  = exc_tval_i;
          w_tgt_nxt    = w_base;
        end else if (w_irq_take) begin
          w_state_nxt  = TRAP_WR;
          w_mepc_nxt   = commit_pc_i;
          w_mcause_nxt = IRQ_CAUSE;
          w_mtval_nxt  = '0;
          w_tgt_nxt    = (csr_mtvec_i[1:0] == 2'b01) ? w_base + VEC_OFS : w_base;
        end else if (mret_valid_i) begin
          w_state_nxt  = MRET_WR;
          w_tgt_nxt    = {csr_mepc_i[XLEN-1:2], 2'b00};
        end
      end
      TRAP_WR:  w_state_nxt = REDIRECT;
      MRET_WR:  w_state_nxt = REDIRECT;
      REDIRECT: if (redirect_ready_i) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
      r_tgt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mepc   <= w_mepc_nxt;
      r_mcause <= w_mcause_nxt;
      r_mtval  <= w_mtval_nxt;
      r_tgt    <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_trap_wr           = (r_state == TRAP_WR);
    w_mret_wr           = (r_state == MRET_WR);
    req_ready_o         = (r_state == IDLE);
    flush_o             = (r_state != IDLE);
    redirect_valid_o    = (r_state == REDIRECT);
    redirect_pc_o       = r_tgt;
    csr_mstatus_valid_o = w_trap_wr | w_mret_wr;
    csr_mepc_valid_o    = w_trap_wr;
    csr_mcause_valid_o  = w_trap_wr;
    csr_mtval_valid_o   = w_trap_wr;
    csr_mepc_o          = r_mepc;
    csr_mcause_o        = r_mcause;
    csr_mtval_o         = r_mtval;
    csr_mstatus_o       = '0;
    if (w_trap_wr)      csr_mstatus_o = mstatus_on_trap(csr_mstatus_i);
    else if (w_mret_wr) csr_mstatus_o = mstatus_on_mret(csr_mstatus_i);
  end

endmodule

// File: tb/tb_rv64_trap_ctrl.sv
// Scoreboard bench for rv64_trap_ctrl: the driver pushes model predictions,
// a negedge monitor compares every cycle of DUT behaviour against them.
module tb_rv64_trap_ctrl;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            exc_valid_i = 1'b0, mret_valid_i = 1'b0, irq_timer_i = 1'b0;
  logic            commit_pc_valid_i = 1'b0, redirect_ready_i = 1'b1;
  logic [XLEN-1:0] exc_cause_i = '0, exc_pc_i = '0, exc_tval_i = '0, commit_pc_i = '0;
  logic [XLEN-1:0] csr_mstatus_i = '0, csr_mepc_i = '0, csr_mtvec_i = '0;
  logic            req_ready_o, flush_o, redirect_valid_o;
  logic [XLEN-1:0] csr_mstatus_o, csr_mepc_o, csr_mcause_o, csr_mtval_o, redirect_pc_o;
  logic            csr_mstatus_valid_o, csr_mepc_valid_o, csr_mcause_valid_o, csr_mtval_valid_o;

  rv64_trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
    .mret_valid_i(mret_valid_i), .irq_timer_i(irq_timer_i),
    .commit_pc_valid_i(commit_pc_valid_i), .commit_pc_i(commit_pc_i),
    .req_ready_o(req_ready_o),
    .csr_mstatus_i(csr_mstatus_i), .csr_mepc_i(csr_mepc_i), .csr_mtvec_i(csr_mtvec_i),
    .csr_mstatus_o(csr_mstatus_o), .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o),
    .csr_mtval_o(csr_mtval_o),
    .csr_mstatus_valid_o(csr_mstatus_valid_o), .csr_mepc_valid_o(csr_mepc_valid_o),
    .csr_mcause_valid_o(csr_mcause_valid_o), .csr_mtval_valid_o(csr_mtval_valid_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          trap;
    logic [63:0] mepc, mcause, mtval, mstatus, target;
    int          acc;
    int          hold;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, hold_cnt = 0, timeouts = 0;
  bit   rr_mode = 0, end_flag = 0, drain_done = 0;
  bit   m_inflight, m_rd;
  logic [3:0] m_strb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference behaviour: what one presented request should produce, if anything.
  function automatic bit model(input bit exc, input logic [63:0] cause, pc, tval,
                               input bit irq, input bit cv, input logic [63:0] cpc,
                               input bit mret, input logic [63:0] ms, mepc, mtvec,
                               output exp_t e);
    logic [63:0] base;
    base = mtvec - (mtvec % 4);
    e = '{default: '0};
    if (exc || (irq && ms[3] && cv)) begin
      e.trap    = 1;
      e.mstatus = (ms & ~64'h1888) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
      if (exc) begin
        e.mepc = pc; e.mcause = cause; e.mtval = tval; e.target = base;
      end else begin
        e.mepc   = cpc;
        e.mcause = 64'h8000_0000_0000_0000 + 7;
        e.mtval  = 0;
        e.target = (mtvec % 4 == 1) ? base + 4 * 7 : base;
      end
      return 1;
    end
    if (mret) begin
      e.trap    = 0;
      e.mstatus = (ms & ~64'h1888) | 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
      e.target  = mepc - (mepc % 4);
      return 1;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    m_strb = {csr_mstatus_valid_o, csr_mepc_valid_o, csr_mcause_valid_o, csr_mtval_valid_o};
    if (!rst) begin
      chk("rst_strobes", m_strb, 0);
      chk("rst_flush", flush_o, 0);
      chk("rst_redirect_valid", redirect_valid_o, 0);
      chk("rst_data", csr_mstatus_o | csr_mepc_o | csr_mcause_o | csr_mtval_o | redirect_pc_o, 0);
      q.delete();
      hold_cnt = 0;
    end else begin
      m_inflight = (q.size() > 0) && (cyc > q[0].acc);
      chk("req_ready", req_ready_o, !m_inflight);
      chk("flush", flush_o, m_inflight);
      if ((q.size() > 0) && (cyc == q[0].acc + 1)) begin
        chk("csr_strobes", m_strb, q[0].trap ? 4'hF : 4'h8);
        chk("mstatus_wr", csr_mstatus_o, q[0].mstatus);
        if (q[0].trap) begin
          chk("mepc_wr", csr_mepc_o, q[0].mepc);
          chk("mcause_wr", csr_mcause_o, q[0].mcause);
          chk("mtval_wr", csr_mtval_o, q[0].mtval);
        end
      end else begin
        chk("strobes_quiet", m_strb, 0);
      end
      m_rd = m_inflight && (cyc >= q[0].acc + 2);
      chk("redirect_valid", redirect_valid_o, m_rd);
      if (m_rd) begin
        chk("redirect_pc", redirect_pc_o, q[0].target);
        hold_cnt++;
        if (redirect_ready_i) begin
          if (q[0].hold > 0) chk("redirect_hold", hold_cnt, q[0].hold);
          void'(q.pop_front());
          hold_cnt = 0;
        end
      end
      if (end_flag && !drain_done) begin
        chk("drain", q.size(), 0);
        chk("ready_timeouts", timeouts, 0);
        drain_done = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rr_mode) redirect_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic present(input bit exc, input logic [63:0] cause, pc, tval,
                         input bit irq, input bit cv, input logic [63:0] cpc,
                         input bit mret, input logic [63:0] ms, mepc, mtvec, input int hold);
    exp_t e;
    exc_valid_i = exc; exc_cause_i = cause; exc_pc_i = pc; exc_tval_i = tval;
    irq_timer_i = irq; commit_pc_valid_i = cv; commit_pc_i = cpc;
    mret_valid_i = mret; csr_mstatus_i = ms; csr_mepc_i = mepc; csr_mtvec_i = mtvec;
    if (model(exc, cause, pc, tval, irq, cv, cpc, mret, ms, mepc, mtvec, e)) begin
      e.acc  = cyc;
      e.hold = hold;
      q.push_back(e);
    end
    step();
    exc_valid_i = 0; irq_timer_i = 0; commit_pc_valid_i = 0; mret_valid_i = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready_o && n < 100) begin
      step();
      n++;
    end
    if (!req_ready_o) timeouts++;
  endtask

  initial begin
    repeat (3) step();
    rst = 1;
    step();
    // Exception with immediate fetch acceptance
    present(1, 64'd2, 64'h8000_0100, 64'hDEAD, 0, 0, 0, 0, 64'h8, 0, 64'h8000_1000, 1);
    wait_idle(); step();
    // Vectored timer interrupt
    present(0, 0, 0, 0, 1, 1, 64'h8000_0200, 0, 64'h8, 0, 64'h8000_1001, 1);
    wait_idle(); step();
    // Masked interrupt must not be accepted
    present(0, 0, 0, 0, 1, 1, 64'h8000_0300, 0, 64'h0, 0, 64'h8000_1001, -1);
    repeat (2) step();
    // mret
    present(0, 0, 0, 0, 0, 0, 0, 1, 64'h1880, 64'h8000_0102, 0, 1);
    wait_idle(); step();
    // All three requests at once, fetch stalled for 4 redirect cycles
    redirect_ready_i = 0;
    present(1, 64'd5, 64'h8000_0400, 64'h44, 1, 1, 64'h8000_0500, 1, 64'h8,
            64'h8000_0600, 64'h8000_2001, 5);
    step();
    mret_valid_i = 1; csr_mepc_i = 64'h1234_5678;
    step(); step();
    mret_valid_i = 0;
    step(); step();
    redirect_ready_i = 1;
    wait_idle(); step();
    // Reset asserted while CSR writes are in progress
    present(1, 64'd7, 64'h8000_0700, 64'h77, 0, 0, 0, 0, 64'h8, 0, 64'h8000_3000, -1);
    rst = 0;
    step(); step();
    rst = 1;
    repeat (6) step();
    // Randomised traffic with random fetch backpressure
    rr_mode = 1;
    repeat (300) begin
      logic [63:0] mtv;
      wait_idle();
      mtv = {$urandom, $urandom};
      mtv[1:0] = 2'($urandom_range(0, 1));
      present($urandom_range(0, 2) == 0, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
              {$urandom, $urandom}, mtv, -1);
    end
    rr_mode = 0;
    redirect_ready_i = 1;
    wait_idle();
    repeat (3) step();
    end_flag = 1;
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
